spi_controller: RTL and testbench

SPI mode-0 controller (initiator) that issues the 16-bit register-access frames consumed by the SPI register-file peripheral. Frame format: bit 15 is R/W (1 = write, 0 = read), bits 14:8 are ADDR[6:0], and bits 7:0 are DATA. All bits are sent MSB first. It accepts one command through a valid/ready handshake, generates nCS/SCLK/COPI with timing slow enough for the peripheral's 2-flop input synchronizers, captures CIPO during the data phase, and returns a one-cycle response. It is used by the on-chip test/config master and as the driver for the peripheral's loopback testbench.

---
 rtl/spi_controller.sv | 157 +++++++++++++++
 tb/tb_spi_controller.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
//  Module   : spi_controller
//  Purpose  : SPI mode-0 initiator issuing 16-bit {R/W, ADDR[6:0], DATA} frames,
//             slow enough for a peripheral with 2-flop input synchronizers.
//  Revision : 1.0  initial release
// ============================================================================
module spi_controller #(
   parameter int CLK_DIV = 4,
   parameter int CS_HOLD = 4,
   parameter int CS_IDLE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       busy,
   output logic       nCS,
   output logic       SCLK,
   output logic       COPI,
   input  logic       CIPO
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOW  = 3'd1,
      S_HIGH = 3'd2,
      S_HOLD = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   localparam logic [7:0] c_DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [7:0] c_HOLD_LAST = 8'(CS_HOLD - 1);
   localparam logic [7:0] c_IDLE_LAST = 8'(CS_IDLE - 1);

   state_t      r_state,     w_state_nxt;
   logic [7:0]  r_div_cnt,   w_div_cnt_nxt;
   logic [3:0]  r_bit_cnt,   w_bit_cnt_nxt;
   logic [14:0] r_shift_tx,  w_shift_nxt;
   logic [7:0]  r_rx,        w_rx_nxt;
   logic        r_ncs,       w_ncs_nxt;
   logic        r_sclk,      w_sclk_nxt;
   logic        r_copi,      w_copi_nxt;
   logic        r_rsp_valid, w_rsp_valid_nxt;
   logic [7:0]  r_rsp_rdata, w_rsp_rdata_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_div_cnt   <= 8'd0;
         r_bit_cnt   <= 4'd0;
         r_shift_tx  <= 15'd0;
         r_rx        <= 8'd0;
         r_ncs       <= 1'b1;
         r_sclk      <= 1'b0;
         r_copi      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 8'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_div_cnt   <= w_div_cnt_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_shift_tx  <= w_shift_nxt;
         r_rx        <= w_rx_nxt;
         r_ncs       <= w_ncs_nxt;
         r_sclk      <= w_sclk_nxt;
         r_copi      <= w_copi_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_div_cnt_nxt   = r_div_cnt + 8'd1;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_shift_nxt     = r_shift_tx;
      w_rx_nxt        = r_rx;
      w_ncs_nxt       = r_ncs;
      w_sclk_nxt      = r_sclk;
      w_copi_nxt      = r_copi;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_rdata_nxt = r_rsp_rdata;
      case (r_state)
         S_IDLE: begin
            w_div_cnt_nxt = 8'd0;
            if (cmd_valid) begin
               // The R/W bit goes straight onto COPI; only the remaining 15 bits are kept.
               w_shift_nxt   = {cmd_addr, cmd_write ? cmd_wdata : 8'h00};
               w_bit_cnt_nxt = 4'd0;
               w_ncs_nxt     = 1'b0;
               w_copi_nxt    = cmd_write;
               w_state_nxt   = S_LOW;
            end
         end
         S_LOW: begin
            if (r_div_cnt == c_DIV_LAST) begin
               w_div_cnt_nxt = 8'd0;
               w_sclk_nxt    = 1'b1;
               w_state_nxt   = S_HIGH;
            end
         end
         S_HIGH: begin
            if (r_div_cnt == c_DIV_LAST) begin
               w_div_cnt_nxt = 8'd0;
               w_sclk_nxt    = 1'b0;
               // Data phase: eight samples taken MSB first fill the whole byte.
               if (r_bit_cnt[3]) begin
                  w_rx_nxt = {r_rx[6:0], CIPO};
               end
               if (r_bit_cnt == 4'd15) begin
                  w_state_nxt = S_HOLD;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                  w_copi_nxt    = r_shift_tx[14];
                  w_shift_nxt   = {r_shift_tx[13:0], 1'b0};
                  w_state_nxt   = S_LOW;
               end
            end
         end
         S_HOLD: begin
            if (r_div_cnt == c_HOLD_LAST) begin
               w_div_cnt_nxt   = 8'd0;
               w_ncs_nxt       = 1'b1;
               w_copi_nxt      = 1'b0;
               w_rsp_rdata_nxt = r_rx;
               w_rsp_valid_nxt = 1'b1;
               w_state_nxt     = S_GAP;
            end
         end
         S_GAP: begin
            if (r_div_cnt == c_IDLE_LAST) begin
               w_div_cnt_nxt = 8'd0;
               w_state_nxt   = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign nCS       = r_ncs;
   assign SCLK      = r_sclk;
   assign COPI      = r_copi;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_controller
//  Purpose  : Self-checking bench for spi_controller with a register-file
//             peripheral model on the serial pins.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_controller;

   localparam int CLK_DIV = 4;
   localparam int CS_HOLD = 4;
   localparam int CS_IDLE = 4;
   localparam int LOW_CYC = 32 * CLK_DIV + CS_HOLD;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b0;
   logic       cmd_valid, cmd_write;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       cmd_ready, rsp_valid, busy, nCS, SCLK, COPI;
   logic [7:0] rsp_rdata;
   logic       CIPO = 1'b0;

   logic       cmd_valid8, cmd_write8;
   logic [6:0] cmd_addr8;
   logic [7:0] cmd_wdata8;
   logic       cmd_ready8, rsp_valid8, busy8, nCS8, SCLK8, COPI8;
   logic [7:0] rsp_rdata8;
   logic       CIPO8 = 1'b0;

   spi_controller #(.CLK_DIV(CLK_DIV), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
      .nCS(nCS), .SCLK(SCLK), .COPI(COPI), .CIPO(CIPO)
   );

   spi_controller #(.CLK_DIV(8), .CS_HOLD(6), .CS_IDLE(4)) dut8 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
      .cmd_write(cmd_write8), .cmd_addr(cmd_addr8), .cmd_wdata(cmd_wdata8),
      .rsp_valid(rsp_valid8), .rsp_rdata(rsp_rdata8), .busy(busy8),
      .nCS(nCS8), .SCLK(SCLK8), .COPI(COPI8), .CIPO(CIPO8)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- peripheral model and frame monitor ----------------
   typedef struct {
      logic [15:0] bits;
      int          rises;
      int          low_cyc;
      int          fall_cyc;
      int          rise_cyc;
   } frame_t;

   frame_t     frm_q[$];
   logic [7:0] rsp_q[$];
   logic [7:0] periph_mem [128];
   logic [7:0] exp_mem    [128];

   int          cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit          mem_init = 1'b0;
   logic        ncs_d = 1'b1, sclk_d = 1'b0;
   logic [15:0] m_bits = 16'd0;
   int          m_rises = 0, m_low = 0, m_fall = 0, cipo_wait = 0;
   logic [7:0]  cipo_byte = 8'd0;

   always @(negedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 128; i++) periph_mem[i] = 8'(i * 30);
         mem_init = 1'b1;
      end
      if (!nCS) begin
         if (ncs_d) begin
            m_bits = 16'd0; m_rises = 0; m_low = 0; m_fall = cyc;
         end
         m_low++;
         // Peripheral updates CIPO two clocks after each data-phase SCLK rise.
         if (cipo_wait > 0) begin
            cipo_wait--;
            if (cipo_wait == 0) begin
               CIPO      = cipo_byte[7];
               cipo_byte = {cipo_byte[6:0], 1'b0};
            end
         end
         if (SCLK && !sclk_d) begin
            m_bits = {m_bits[14:0], COPI};
            m_rises++;
            if (m_rises == 8) cipo_byte = periph_mem[m_bits[6:0]];
            if (m_rises >= 9) cipo_wait = 2;
         end
      end else if (!ncs_d) begin
         frm_q.push_back('{m_bits, m_rises, m_low, m_fall, cyc});
         if (m_rises == 16 && m_bits[15]) periph_mem[m_bits[14:8]] = m_bits[7:0];
         cipo_wait = 0;
      end
      if (rsp_valid) rsp_q.push_back(rsp_rdata);
      ncs_d  = nCS;
      sclk_d = SCLK;
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_cmd(input logic w, input logic [6:0] a, input logic [7:0] d);
      int t = 0;
      @(negedge clk); #1;
      while (!cmd_ready && t < 1000) begin @(negedge clk); #1; t++; end
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom); cmd_addr = 7'($urandom); cmd_wdata = 8'($urandom);
   endtask

   task automatic finish_frame(input string name, input logic [15:0] exp_frame,
                               input bit chk_rd, input logic [7:0] exp_rd, output frame_t f);
      logic [7:0] rd;
      int t = 0;
      f = '{16'd0, 0, 0, 0, 0};
      while ((rsp_q.size() == 0 || frm_q.size() == 0) && t < 1000) begin
         @(negedge clk); #1; t++;
      end
      if (rsp_q.size() == 0 || frm_q.size() == 0) begin
         check({name, " response timeout"}, 32'd0, 32'd1);
         return;
      end
      f  = frm_q.pop_front();
      rd = rsp_q.pop_front();
      check({name, " frame"},   32'(f.bits), 32'(exp_frame));
      check({name, " rises"},   32'(f.rises), 32'd16);
      check({name, " ncs_low"}, 32'(f.low_cyc), 32'(LOW_CYC));
      if (chk_rd) check({name, " rdata"}, 32'(rd), 32'(exp_rd));
      if (exp_frame[15]) exp_mem[exp_frame[14:8]] = exp_frame[7:0];
   endtask

   task automatic settle(input string name);
      int t = 0;
      while (!cmd_ready && t < 100) begin @(negedge clk); #1; t++; end
      check({name, " extra rsp/frame"}, 32'(rsp_q.size() + frm_q.size()), 32'd0);
   endtask

   typedef struct {
      logic        w;
      logic [6:0]  a;
      logic [7:0]  d;
      logic [15:0] exp_frame;
      logic [7:0]  exp_rd;
   } vec_t;

   vec_t vec [10];

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_t f, fa, fb;
      logic   w;
      logic [6:0] a;
      logic [7:0] d, er;
      int t, cnt;

      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
      cmd_valid8 = 0; cmd_write8 = 0; cmd_addr8 = 0; cmd_wdata8 = 0;
      for (int i = 0; i < 128; i++) exp_mem[i] = 8'(i * 30);

      vec[0] = '{1'b1, 7'h04, 8'hA5, 16'h84A5, 8'h00};
      vec[1] = '{1'b0, 7'h02, 8'hEE, 16'h0200, 8'h3C};
      vec[2] = '{1'b0, 7'h04, 8'h11, 16'h0400, 8'hA5};
      vec[3] = '{1'b1, 7'h7F, 8'h5A, 16'hFF5A, 8'h00};
      vec[4] = '{1'b0, 7'h7F, 8'hFF, 16'h7F00, 8'h5A};
      vec[5] = '{1'b1, 7'h00, 8'hFF, 16'h80FF, 8'h00};
      vec[6] = '{1'b0, 7'h00, 8'h00, 16'h0000, 8'hFF};
      vec[7] = '{1'b1, 7'h02, 8'h00, 16'h8200, 8'h00};
      vec[8] = '{1'b0, 7'h02, 8'hC3, 16'h0200, 8'h00};
      vec[9] = '{1'b0, 7'h55, 8'h81, 16'h5500, 8'hF6};

      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("reset outputs", 32'({cmd_ready, busy, nCS, SCLK, COPI, rsp_valid, rsp_rdata}),
            32'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
      check("reset outputs clk_div8", 32'({cmd_ready8, busy8, nCS8, SCLK8, COPI8, rsp_valid8, rsp_rdata8}),
            32'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
      rst = 1'b0;

      // Table-driven frames
      for (int i = 0; i < 10; i++) begin
         start_cmd(vec[i].w, vec[i].a, vec[i].d);
         finish_frame($sformatf("vec%0d", i), vec[i].exp_frame, !vec[i].w, vec[i].exp_rd, f);
         settle($sformatf("vec%0d", i));
      end

      // Back-to-back with cmd_valid held high
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h21; cmd_wdata = 8'h3C;
      t = 0;
      while (!cmd_ready && t < 100) begin @(negedge clk); #1; t++; end
      @(posedge clk); #1;
      cmd_addr = 7'h22; cmd_wdata = 8'hC3;
      cnt = 0; t = 0;
      while (!cmd_ready && t < 1000) begin
         @(negedge clk); #1; t++;
         if (!cmd_ready) cnt++;
      end
      check("b2b ready low cycles", 32'(cnt), 32'(LOW_CYC + CS_IDLE));
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("b2b second accepted", 32'(busy), 32'd1);
      finish_frame("b2b A", 16'hA13C, 1'b0, 8'h00, fa);
      finish_frame("b2b B", 16'hA2C3, 1'b0, 8'h00, fb);
      check("b2b nCS gap", 32'(fb.fall_cyc - fa.rise_cyc), 32'(CS_IDLE + 1));
      settle("b2b");

      // Command inputs ignored while busy
      start_cmd(1'b1, 7'h30, 8'h96);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cmd_valid = (i % 2 == 1);
         cmd_write = 1'($urandom); cmd_addr = 7'($urandom); cmd_wdata = 8'($urandom);
      end
      cmd_valid = 1'b0;
      finish_frame("busy ignore", 16'hB096, 1'b0, 8'h00, f);
      settle("busy ignore");
      repeat (200) @(negedge clk);
      #1;
      check("busy ignore no extra frame", 32'({frm_q.size(), 1'b0} | {31'd0, busy}), 32'd0);

      // Asynchronous reset during bit 7
      start_cmd(1'b1, 7'h11, 8'h5A);
      t = 0;
      while (m_rises != 8 && t < 500) begin @(negedge clk); #1; t++; end
      check("abort reached bit7", 32'({SCLK, COPI}), 32'b11);
      #2 rst = 1'b1;
      #1;
      check("abort async outputs", 32'({nCS, SCLK, COPI, rsp_valid, busy}), 32'b10000);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("abort no rsp", 32'(rsp_q.size()), 32'd0);
      check("abort rdata cleared", 32'(rsp_rdata), 32'd0);
      if (frm_q.size() > 0) begin
         f = frm_q.pop_front();
         check("abort partial rises", 32'(f.rises), 32'd8);
      end else begin
         check("abort partial frame seen", 32'd0, 32'd1);
      end
      start_cmd(1'b0, 7'h11, 8'h00);
      finish_frame("after abort read", 16'h1100, 1'b1, exp_mem[7'h11], f);
      settle("after abort");

      // Randomized traffic against the reference memory
      for (int i = 0; i < 30; i++) begin
         w  = 1'($urandom_range(0, 1));
         a  = 7'($urandom_range(0, 15));
         d  = 8'($urandom);
         er = exp_mem[a];
         start_cmd(w, a, d);
         finish_frame($sformatf("rand%0d", i), {w, a, w ? d : 8'h00}, !w, er, f);
         settle($sformatf("rand%0d", i));
      end

      cnt = 0;
      for (int i = 0; i < 128; i++) if (periph_mem[i] !== exp_mem[i]) cnt++;
      check("peripheral register mismatches", 32'(cnt), 32'd0);

      // Slow instance: CLK_DIV=8, CS_HOLD=6
      begin
         int lowc = 0, hr = 0, lr = 0, hmin = 999, hmax = 0, lmin = 999, lmax = 0, rises8 = 0;
         logic [15:0] bits8 = 16'd0;
         logic ps = 1'b0, rsp8 = 1'b0;
         bit seen_low = 1'b0;
         @(negedge clk);
         cmd_valid8 = 1'b1; cmd_write8 = 1'b1; cmd_addr8 = 7'h00; cmd_wdata8 = 8'hFF;
         @(posedge clk); #1;
         cmd_valid8 = 1'b0;
         for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (!nCS8) begin
               seen_low = 1'b1;
               lowc++;
               if (SCLK8) begin
                  if (!ps) begin
                     rises8++;
                     bits8 = {bits8[14:0], COPI8};
                     if (lr < lmin) lmin = lr;
                     if (lr > lmax) lmax = lr;
                     lr = 0;
                  end
                  hr++;
               end else begin
                  if (ps) begin
                     if (hr < hmin) hmin = hr;
                     if (hr > hmax) hmax = hr;
                     hr = 0;
                  end
                  lr++;
               end
               ps = SCLK8;
            end else if (seen_low) begin
               rsp8 = rsp_valid8;
               break;
            end
         end
         check("div8 frame",         32'(bits8), 32'h80FF);
         check("div8 rises",         32'(rises8), 32'd16);
         check("div8 ncs_low",       32'(lowc), 32'd262);
         check("div8 high phase",    32'({hmin[15:0], hmax[15:0]}), 32'h0008_0008);
         check("div8 low phase",     32'({lmin[15:0], lmax[15:0]}), 32'h0008_0008);
         check("div8 rsp_valid",     32'(rsp8), 32'd1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
